// File: rtl/pipelined_adder_tree.sv
// ---------------------------------------------------------------------------
// pipelined_adder_tree
//
// Sums N_INPUTS unsigned IN_WIDTH-bit operands through a registered binary
// tree. Each tree level has one register stage, so the latency is
// LEVELS = $clog2(N_INPUTS) cycles. Every addition widens by one bit, which
// gives a full-precision OUT_WIDTH = IN_WIDTH + LEVELS result.
//
// Ports:
//   clk        single clock, rising edge
//   rst        synchronous, active-high reset
//   in_data    packed operands, operand i = in_data[i*IN_WIDTH +: IN_WIDTH]
//   in_valid   operand set valid
//   in_ready   block can accept this cycle (combinational from output side)
//   out_data   sum of one accepted operand set
//   out_valid  out_data valid
//   out_ready  downstream accepts out_data
//   acc_clear  accumulator clear          (only with ADDER_TREE_ACC_EN)
//   acc_out    running accumulator        (only with ADDER_TREE_ACC_EN)
//
// Optional feature macro: ADDER_TREE_ACC_EN adds a wrapping accumulator of
// consumed sums. Core behaviour is identical with or without it.
//
// Flow control is a global stall: when the output holds valid data that is
// not being taken, every stage freezes. Bubbles are not compressed.
// ---------------------------------------------------------------------------
module pipelined_adder_tree #(
    parameter  int N_INPUTS  = 4,
    parameter  int IN_WIDTH  = 8,
    localparam int LEVELS    = $clog2(N_INPUTS),
    localparam int OUT_WIDTH = IN_WIDTH + LEVELS
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic [N_INPUTS*IN_WIDTH-1:0] in_data,
    input  logic                         in_valid,
    output logic                         in_ready,
    output logic [OUT_WIDTH-1:0]         out_data,
    output logic                         out_valid,
    input  logic                         out_ready
`ifdef ADDER_TREE_ACC_EN
    ,
    input  logic                         acc_clear,
    output logic [OUT_WIDTH+7:0]         acc_out
`endif
);

    logic              en;
    logic [LEVELS:1]   v_reg;

    // Whole pipeline advances unless the output is holding unconsumed data.
    assign en       = !out_valid || out_ready;
    assign in_ready = en;

    // Valid bits travel alongside the data. Stage 1 data loads even when
    // in_valid is low; the valid bit marks it as a bubble.
    always_ff @(posedge clk) begin
        if (rst) begin
            v_reg <= '0;
        end else if (en) begin
            v_reg[1] <= in_valid;
            for (int k = 2; k <= LEVELS; k++) begin
                v_reg[k] <= v_reg[k-1];
            end
        end
    end

    genvar gi;
    generate
        for (gi = 1; gi <= LEVELS; gi++) begin : gen_level
            localparam int NS = N_INPUTS >> gi;   // partial sums at this level
            localparam int SW = IN_WIDTH + gi;    // width of each partial sum

            logic [SW-1:0] sum_reg  [NS];
            logic [SW-1:0] sum_next [NS];

            if (gi == 1) begin : gen_leaf
                // First level pairs operands (2j, 2j+1) straight from the input.
                always_comb begin
                    for (int j = 0; j < NS; j++) begin
                        sum_next[j] = {1'b0, in_data[(2*j)*IN_WIDTH +: IN_WIDTH]}
                                    + {1'b0, in_data[(2*j+1)*IN_WIDTH +: IN_WIDTH]};
                    end
                end
            end else begin : gen_inner
                // Later levels pair adjacent sums of the previous level.
                always_comb begin
                    for (int j = 0; j < NS; j++) begin
                        sum_next[j] = {1'b0, gen_level[gi-1].sum_reg[2*j]}
                                    + {1'b0, gen_level[gi-1].sum_reg[2*j+1]};
                    end
                end
            end

            always_ff @(posedge clk) begin
                if (rst) begin
                    for (int j = 0; j < NS; j++) begin
                        sum_reg[j] <= '0;
                    end
                end else if (en) begin
                    for (int j = 0; j < NS; j++) begin
                        sum_reg[j] <= sum_next[j];
                    end
                end
            end
        end
    endgenerate

    assign out_data  = gen_level[LEVELS].sum_reg[0];
    assign out_valid = v_reg[LEVELS];

`ifdef ADDER_TREE_ACC_EN
    logic [OUT_WIDTH+7:0] acc_reg;
    logic                 out_fire;

    assign out_fire = out_valid && out_ready;

    // Clear wins over accumulate, but a sum consumed in the clearing cycle
    // becomes the new starting value rather than being lost.
    always_ff @(posedge clk) begin
        if (rst) begin
            acc_reg <= '0;
        end else if (acc_clear) begin
            acc_reg <= out_fire ? {8'd0, out_data} : '0;
        end else if (out_fire) begin
            acc_reg <= acc_reg + {8'd0, out_data};
        end
    end

    assign acc_out = acc_reg;
`endif

endmodule

// File: tb/tb_pipelined_adder_tree.sv
// ---------------------------------------------------------------------------
// tb_pipelined_adder_tree
//
// Self-checking bench for pipelined_adder_tree with N_INPUTS=4, IN_WIDTH=8.
// A queue of expected sums (computed by plain addition at acceptance time)
// is popped and compared whenever the DUT hands off a result.
// ---------------------------------------------------------------------------
module tb_pipelined_adder_tree;

    localparam int N  = 4;
    localparam int IW = 8;
    localparam int OW = 10;
    localparam int AW = OW + 8;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic [N*IW-1:0]   in_data = '0;
    logic              in_valid = 1'b0;
    logic              in_ready;
    logic [OW-1:0]     out_data;
    logic              out_valid;
    logic              out_ready = 1'b0;
`ifdef ADDER_TREE_ACC_EN
    logic              acc_clear = 1'b0;
    logic [AW-1:0]     acc_out;
`endif

    int checks = 0;
    int errors = 0;
    int unsigned exp_q[$];
    longint unsigned acc_model = 0;

    always #5 clk = ~clk;

    pipelined_adder_tree #(.N_INPUTS(N), .IN_WIDTH(IW)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_data   (in_data),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .out_data  (out_data),
        .out_valid (out_valid),
        .out_ready (out_ready)
`ifdef ADDER_TREE_ACC_EN
        ,
        .acc_clear (acc_clear),
        .acc_out   (acc_out)
`endif
    );

    function automatic logic [N*IW-1:0] pack4(input int a0, input int a1,
                                              input int a2, input int a3);
        logic [N*IW-1:0] p;
        p = {a3[7:0], a2[7:0], a1[7:0], a0[7:0]};
        return p;
    endfunction

    function automatic int unsigned ref_sum(input logic [N*IW-1:0] d);
        int unsigned s = 0;
        for (int i = 0; i < N; i++) s += d[i*IW +: IW];
        return s;
    endfunction

    // One clock cycle: drive, observe handshakes, update the model, step.
    task automatic cyc(input bit v, input logic [N*IW-1:0] d, input bit r);
        bit acc_now, con;
        int unsigned e;
        in_valid = v; in_data = d; out_ready = r;
        #1;
        acc_now = in_valid && in_ready;
        con     = out_valid && out_ready;
        if (con) begin
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL unexpected_output: got %0d, required no output", out_data);
            end else begin
                e = exp_q.pop_front();
                if (out_data !== OW'(e)) begin
                    errors++;
                    $display("FAIL output_order: got %0d, required %0d", out_data, e);
                end else begin
                    $display("out %0d", out_data);
                end
            end
        end
`ifdef ADDER_TREE_ACC_EN
        if (acc_clear) acc_model = con ? longint'(out_data) : 0;
        else if (con)  acc_model = (acc_model + out_data) % (64'd1 << AW);
`endif
        @(posedge clk);
        if (acc_now) exp_q.push_back(ref_sum(d));
        #1;
`ifdef ADDER_TREE_ACC_EN
        checks++;
        if (acc_out !== AW'(acc_model)) begin
            errors++;
            $display("FAIL acc_track: got %0d, required %0d", acc_out, acc_model);
        end
`endif
    endtask

    task automatic flush();
        int n = 0;
        while (exp_q.size() != 0 && n < 20) begin
            cyc(1'b0, '0, 1'b1);
            n++;
        end
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL flush_timeout: %0d results still pending, required 0", exp_q.size());
        end
    endtask

    task automatic do_reset();
        rst = 1'b1; in_valid = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        exp_q.delete();
        acc_model = 0;
    endtask

    // Present one set, then idle: result must appear exactly two cycles on.
    task automatic send_one(input logic [N*IW-1:0] d, input int unsigned expv);
        cyc(1'b1, d, 1'b1);
        checks++;
        if (out_valid !== 1'b0) begin
            errors++;
            $display("FAIL early_valid: got %b, required 0", out_valid);
        end
        cyc(1'b0, '0, 1'b1);
        checks++;
        if (out_valid !== 1'b1 || out_data !== OW'(expv)) begin
            errors++;
            $display("FAIL latency: got valid=%b data=%0d, required valid=1 data=%0d",
                     out_valid, out_data, expv);
        end
        cyc(1'b0, '0, 1'b1);
        checks++;
        if (out_valid !== 1'b0) begin
            errors++;
            $display("FAIL valid_one_cycle: got %b, required 0", out_valid);
        end
    endtask

    task automatic test_reset();
        do_reset();
        checks++;
        if (out_valid !== 1'b0 || out_data !== '0 || in_ready !== 1'b1) begin
            errors++;
            $display("FAIL reset_state: got valid=%b data=%0d ready=%b, required 0 0 1",
                     out_valid, out_data, in_ready);
        end else $display("reset state ok");
    endtask

    task automatic test_basic();
        send_one(pack4(1, 255, 9, 10), 275);
        send_one(pack4(0, 3, 1, 255), 259);
    endtask

    task automatic test_max();
        send_one(pack4(255, 255, 255, 255), 1020);
        send_one(pack4(0, 0, 0, 0), 0);
    endtask

    task automatic test_back_to_back();
        logic [N*IW-1:0] sets [4];
        sets[0] = pack4(15, 15, 109, 37);
        sets[1] = pack4(0, 9, 45, 45);
        sets[2] = pack4(10, 13, 9, 10);
        sets[3] = pack4(1, 1, 1, 1);
        for (int i = 0; i < 6; i++) begin
            cyc(i < 4, (i < 4) ? sets[i] : '0, 1'b1);
            if (i >= 1) begin
                checks++;
                if (out_valid !== (i <= 4)) begin
                    errors++;
                    $display("FAIL b2b_valid[%0d]: got %b, required %b", i, out_valid, (i <= 4));
                end
            end
        end
        flush();
    endtask

    task automatic test_backpressure();
        cyc(1'b1, pack4(15, 15, 109, 37), 1'b1);
        cyc(1'b1, pack4(0, 9, 45, 45), 1'b1);
        for (int i = 0; i < 3; i++) begin
            cyc(1'b1, pack4(10, 13, 9, 10), 1'b0);
            checks++;
            if (out_valid !== 1'b1 || out_data !== 10'd176 || in_ready !== 1'b0) begin
                errors++;
                $display("FAIL stall[%0d]: got valid=%b data=%0d ready=%b, required 1 176 0",
                         i, out_valid, out_data, in_ready);
            end
        end
        cyc(1'b1, pack4(10, 13, 9, 10), 1'b1);
        checks++;
        if (out_valid !== 1'b1 || out_data !== 10'd99) begin
            errors++;
            $display("FAIL release: got valid=%b data=%0d, required 1 99", out_valid, out_data);
        end
        cyc(1'b0, '0, 1'b1);
        checks++;
        if (out_valid !== 1'b1 || out_data !== 10'd42) begin
            errors++;
            $display("FAIL release2: got valid=%b data=%0d, required 1 42", out_valid, out_data);
        end
        flush();
    endtask

    task automatic test_reset_midflight();
        cyc(1'b1, pack4(1, 2, 3, 4), 1'b1);
        in_valid = 1'b1; in_data = pack4(5, 6, 7, 8); rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0; in_valid = 1'b0;
        exp_q.delete();
        acc_model = 0;
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (out_valid !== 1'b0 || out_data !== '0 || in_ready !== 1'b1) begin
                errors++;
                $display("FAIL reset_flight[%0d]: got valid=%b data=%0d ready=%b, required 0 0 1",
                         i, out_valid, out_data, in_ready);
            end
            cyc(1'b0, '0, 1'b1);
        end
    endtask

    task automatic test_random();
        for (int i = 0; i < 300; i++) begin
            cyc(($urandom_range(0, 3) != 0), N*IW'($urandom), ($urandom_range(0, 2) != 0));
        end
        flush();
    endtask

`ifdef ADDER_TREE_ACC_EN
    task automatic test_acc();
        do_reset();
        send_one(pack4(1, 255, 9, 10), 275);
        send_one(pack4(255, 255, 255, 255), 1020);
        send_one(pack4(1, 1, 1, 1), 4);
        checks++;
        if (acc_out !== 18'd1299) begin
            errors++;
            $display("FAIL acc_sum: got %0d, required 1299", acc_out);
        end
        cyc(1'b1, pack4(0, 9, 45, 45), 1'b1);
        cyc(1'b0, '0, 1'b1);
        acc_clear = 1'b1;
        cyc(1'b0, '0, 1'b1);
        acc_clear = 1'b0;
        checks++;
        if (acc_out !== 18'd99) begin
            errors++;
            $display("FAIL acc_clear: got %0d, required 99", acc_out);
        end
        do_reset();
        checks++;
        if (acc_out !== '0) begin
            errors++;
            $display("FAIL acc_reset: got %0d, required 0", acc_out);
        end
    endtask
`endif

    initial begin
        test_reset();
        test_basic();
        test_max();
        test_back_to_back();
        test_backpressure();
        test_reset_midflight();
        test_random();
`ifdef ADDER_TREE_ACC_EN
        test_acc();
`endif
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
